// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall vectors, FSM encoding,
// default exception vector and the stall-priority helper.
package pipeline_ctrl_pkg;

    // Stall vector bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;
    localparam int          WDOG_W             = 8;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // The deepest stalling stage wins: it must also hold everything upstream.
    function automatic logic [5:0] stall_prio(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [5:0] v;
        v = STALL_NONE;
        if (req_mem)     v = STALL_MEM;
        else if (req_ex) v = STALL_EX;
        else if (req_id) v = STALL_ID;
        else if (req_if) v = STALL_IF;
        return v;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline stages and the controller: per-stage stall
// requests and exception commit in, stall/flush/redirect controls out.
interface pipeline_ctrl_if #(
    parameter int ADDR_W = 32
);
    import pipeline_ctrl_pkg::*;

    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              exc_valid;
    logic              exc_eret;
    logic [ADDR_W-1:0] epc;

    logic [5:0]        stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              bus_err;
    logic              busy;
    state_t            dbg_state;

    // Stall is a level, not a handshake: a stage holds its register for every
    // cycle its bit is 1; flush is sampled by all stage registers on the edge.
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output exc_valid, exc_eret, epc,
        input  stall, flush, new_pc, bus_err, busy, dbg_state
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  exc_valid, exc_eret, epc,
        output stall, flush, new_pc, bus_err, busy, dbg_state
    );

endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Counts consecutive data-memory wait cycles while the pipeline runs and flags
// expiry on the cycle the count reaches MEM_TIMEOUT.
module stall_watchdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_mem_req,
    output logic o_expire
);

    localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(MEM_TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] MAX_CNT  = {WDOG_W{1'b1}};

    logic [WDOG_W-1:0] r_cnt;
    logic              w_counting;

    assign w_counting = i_run && i_mem_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_counting) begin
            r_cnt <= '0;
        end else if (r_cnt != MAX_CNT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = w_counting && (r_cnt == LAST_CNT);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stage stall requests and sequences exception,
// ERET and bus-error redirects through RUN -> FREEZE -> FLUSH.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR  = ADDR_W'(EXC_VECTOR_DEFAULT),
    parameter int                MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_ctrl_if.slave         bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] w_target_nxt;
    logic              r_flush;
    logic [ADDR_W-1:0] r_new_pc;
    logic              r_bus_err;
    logic              r_busy;
    logic              w_run;
    logic              w_expire;
    logic              w_redirect;
    logic              w_bus_err_evt;
    logic [5:0]        w_stall;

    assign w_run = (r_state == ST_RUN);

    stall_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_run),
        .i_mem_req (bus.stallreq_mem),
        .o_expire  (w_expire)
    );

    // A committed exception outranks a simultaneous watchdog expiry.
    assign w_bus_err_evt = w_run && w_expire && !bus.exc_valid;
    assign w_target_nxt  = (bus.exc_valid && bus.exc_eret) ? bus.epc : EXC_VECTOR;

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = STALL_NONE;
        w_redirect  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_redirect = bus.exc_valid || w_expire;
                if (w_redirect) begin
                    w_stall     = STALL_ALL;
                    w_state_nxt = ST_FREEZE;
                end else begin
                    w_stall = stall_prio(bus.stallreq_if, bus.stallreq_id,
                                         bus.stallreq_ex, bus.stallreq_mem);
                end
            end
            ST_FREEZE: begin
                w_stall     = STALL_ALL;
                w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_stall     = STALL_NONE;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_stall     = STALL_NONE;
                w_state_nxt = ST_RUN;
            end
        endcase
        // Stall is combinational, so it must be forced quiet during reset too.
        if (rst) begin
            w_stall = STALL_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target  <= '0;
            r_flush   <= 1'b0;
            r_new_pc  <= '0;
            r_bus_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_target <= w_target_nxt;
            end
            // The target is published one cycle after capture so flush and
            // new_pc rise together on the FREEZE -> FLUSH edge.
            if (r_state == ST_FREEZE) begin
                r_new_pc <= r_target;
            end
            r_flush   <= (r_state == ST_FREEZE);
            r_bus_err <= w_bus_err_evt;
            r_busy    <= (w_state_nxt != ST_RUN);
        end
    end

    assign bus.stall     = w_stall;
    assign bus.flush     = r_flush;
    assign bus.new_pc    = r_new_pc;
    assign bus.bus_err   = r_bus_err;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule
